// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: sequential single-outstanding fetch from instruction memory
// into a small FIFO, with id tagging and redirect/flush handling.
module inst_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IID_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ireq_valid,
  input  logic [31:0]          ireq_addr,
  output logic                 iresp_valid,
  input  logic                 iresp_ready,
  output logic [31:0]          iresp_addr,
  output logic [31:0]          iresp_inst,
  output logic [IID_WIDTH-1:0] iresp_inst_id,
  output logic                 mreq_valid,
  input  logic                 mreq_ready,
  output logic [31:0]          mreq_addr,
  input  logic                 mresp_valid,
  input  logic [31:0]          mresp_data
);

  // state  | meaning
  // S_IDLE | no request in flight, waiting for queue space
  // S_REQ  | mreq_valid held, waiting for mreq_ready
  // S_WAIT | request accepted, waiting for mresp_valid
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t               state, state_nxt;
  logic                 discard, discard_nxt;
  logic [31:0]          fetch_pc;
  logic [IID_WIDTH-1:0] next_id;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_nxt;
  logic [31:0]          pc_mem   [DEPTH];
  logic [31:0]          inst_mem [DEPTH];
  logic [IID_WIDTH-1:0] id_mem   [DEPTH];

  logic flush, push, pop, space_nxt;

  assign flush     = ireq_valid;
  assign push      = (state == S_WAIT) && mresp_valid && !discard && !flush;
  assign pop       = iresp_valid && iresp_ready && !flush;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign space_nxt = count_nxt < CW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    case (state)
      S_IDLE: begin
        if (!flush && (count < CW'(DEPTH))) state_nxt = S_REQ;
      end
      S_REQ: begin
        // without a handshake a redirect just retargets mreq_addr via fetch_pc
        if (mreq_ready) begin
          state_nxt = S_WAIT;
          if (flush) discard_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (mresp_valid) begin
          discard_nxt = 1'b0;
          if (flush)          state_nxt = S_IDLE;
          else if (space_nxt) state_nxt = S_REQ;
          else                state_nxt = S_IDLE;
        end else if (flush) begin
          discard_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        discard_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    mreq_valid = (state == S_REQ);
    mreq_addr  = fetch_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      next_id  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
        id_mem[i]   <= '0;
      end
    end else if (flush) begin
      // ids keep counting across flushes so they stay unique
      fetch_pc <= {ireq_addr[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        inst_mem[wr_ptr] <= mresp_data;
        id_mem[wr_ptr]   <= next_id;
        wr_ptr           <= wr_ptr + PW'(1);
        fetch_pc         <= fetch_pc + 32'd4;
        next_id          <= next_id + IID_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  assign iresp_valid   = (count != '0);
  assign iresp_addr    = pc_mem[rd_ptr];
  assign iresp_inst    = inst_mem[rd_ptr];
  assign iresp_inst_id = id_mem[rd_ptr];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small latency-programmable memory responder
// and logs of accepted requests and popped instructions.
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_valid;
  logic        iresp_ready;
  logic [31:0] iresp_addr;
  logic [31:0] iresp_inst;
  logic [63:0] iresp_inst_id;
  logic        mreq_valid;
  logic        mreq_ready;
  logic [31:0] mreq_addr;
  logic        mresp_valid;
  logic [31:0] mresp_data;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] req_log[$];
  logic [31:0] pop_addr[$];
  logic [31:0] pop_inst[$];
  logic [63:0] pop_id[$];

  int          mem_lat;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .IID_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_valid(iresp_valid), .iresp_ready(iresp_ready),
    .iresp_addr(iresp_addr), .iresp_inst(iresp_inst), .iresp_inst_id(iresp_inst_id),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_addr(mreq_addr),
    .mresp_valid(mresp_valid), .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes seen before the edge, then update the memory model after it.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = mreq_valid && mreq_ready && rst_n;
    a  = mreq_addr;
    if (hs) req_log.push_back(a);
    if (iresp_valid && iresp_ready && !ireq_valid && rst_n) begin
      pop_addr.push_back(iresp_addr);
      pop_inst.push_back(iresp_inst);
      pop_id.push_back(iresp_inst_id);
    end
    @(posedge clk);
    #1;
    ireq_valid  = 1'b0;
    mresp_valid = 1'b0;
    if (hs) begin
      pend = 1'b1; pend_cnt = mem_lat; pend_addr = a;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mresp_valid = 1'b1;
        mresp_data  = memf(pend_addr);
        pend        = 1'b0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    req_log.delete(); pop_addr.delete(); pop_inst.delete(); pop_id.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pend = 1'b0; mresp_valid = 1'b0; ireq_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until_req(input string tag, input int n);
    for (int i = 0; i < 60 && req_log.size() < n; i++) tick();
    check_vec(tag, 64'(req_log.size()), 64'(n));
  endtask

  task automatic redirect(input logic [31:0] a);
    ireq_valid = 1'b1; ireq_addr = a;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ireq_valid = 1'b0; ireq_addr = '0; iresp_ready = 1'b1;
    mreq_ready = 1'b1; mresp_valid = 1'b0; mresp_data = '0;
    mem_lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;

    // reset state
    tick();
    check_vec("rst_iresp_valid", 64'(iresp_valid), 64'd0);
    check_vec("rst_mreq_valid", 64'(mreq_valid), 64'd0);
    check_vec("rst_iresp_addr", 64'(iresp_addr), 64'd0);
    check_vec("rst_iresp_inst", 64'(iresp_inst), 64'd0);
    check_vec("rst_iresp_id", iresp_inst_id, 64'd0);
    check_vec("rst_mreq_addr", 64'(mreq_addr), 64'd0);

    // cold start
    do_reset();
    ticks(20);
    check_vec("cold_req0", 64'(req_log[0]), 64'h0);
    check_vec("cold_req1", 64'(req_log[1]), 64'h4);
    check_vec("cold_req2", 64'(req_log[2]), 64'h8);
    for (int k = 0; k < 3; k++) begin
      check_vec($sformatf("cold_pop%0d_addr", k), 64'(pop_addr[k]), 64'(32'(4 * k)));
      check_vec($sformatf("cold_pop%0d_id", k), pop_id[k], 64'(k));
      check_vec($sformatf("cold_pop%0d_inst", k), 64'(pop_inst[k]), 64'({16'hC0DE, 16'(4 * k)}));
    end

    // back-pressure fills exactly DEPTH entries
    do_reset();
    iresp_ready = 1'b0;
    ticks(30);
    check_vec("bp_req_count", 64'(req_log.size()), 64'd4);
    check_vec("bp_req_last", 64'(req_log[3]), 64'hC);
    check_vec("bp_mreq_idle", 64'(mreq_valid), 64'd0);
    check_vec("bp_head_valid", 64'(iresp_valid), 64'd1);
    check_vec("bp_head_addr", 64'(iresp_addr), 64'h0);
    check_vec("bp_head_id", iresp_inst_id, 64'd0);
    iresp_ready = 1'b1;
    ticks(20);
    for (int k = 0; k < 4; k++) begin
      check_vec($sformatf("bp_drain%0d_id", k), pop_id[k], 64'(k));
      check_vec($sformatf("bp_drain%0d_addr", k), 64'(pop_addr[k]), 64'(32'(4 * k)));
    end
    check_vec("bp_resume_addr", 64'(req_log[4]), 64'h10);

    // redirect in WAIT with the 0x8 response arriving that cycle
    do_reset();
    run_until_req("rw_wait_req", 3);
    redirect(32'h100);
    check_vec("rw_flush_empty", 64'(iresp_valid), 64'd0);
    ticks(10);
    check_vec("rw_next_req", 64'(req_log[3]), 64'h100);
    check_vec("rw_pop_count", 64'(pop_addr.size() >= 3), 64'd1);
    check_vec("rw_pop1_addr", 64'(pop_addr[1]), 64'h4);
    check_vec("rw_pop2_addr", 64'(pop_addr[2]), 64'h100);
    check_vec("rw_pop2_id", pop_id[2], 64'd2);
    check_vec("rw_pop2_inst", 64'(pop_inst[2]), 64'hC0DE_0100);

    // redirects while a response is still pending: discarded, second target wins
    do_reset();
    mem_lat = 3;
    run_until_req("rd_wait_req", 1);
    redirect(32'h100);
    redirect(32'h182);
    ticks(15);
    check_vec("rd_next_req", 64'(req_log[1]), 64'h180);
    check_vec("rd_pop0_addr", 64'(pop_addr[0]), 64'h180);
    check_vec("rd_pop0_id", pop_id[0], 64'd0);
    check_vec("rd_pop0_inst", 64'(pop_inst[0]), 64'hC0DE_0180);
    mem_lat = 1;

    // redirect in the same cycle as a pop and a push
    do_reset();
    iresp_ready = 1'b0;
    run_until_req("pp_setup", 2);
    check_vec("pp_pre_valid", 64'(iresp_valid && mresp_valid), 64'd1);
    iresp_ready = 1'b1;
    redirect(32'h203);
    check_vec("pp_empty", 64'(iresp_valid), 64'd0);
    check_vec("pp_fetch_pc", 64'(mreq_addr), 64'h200);
    check_vec("pp_no_pop", 64'(pop_addr.size()), 64'd0);
    ticks(10);
    check_vec("pp_next_req", 64'(req_log[2]), 64'h200);
    check_vec("pp_pop0_addr", 64'(pop_addr[0]), 64'h200);
    check_vec("pp_pop0_id", pop_id[0], 64'd1);

    // redirect while the request is stalled by mreq_ready=0
    do_reset();
    mreq_ready = 1'b0;
    ticks(5);
    check_vec("st_mreq_valid", 64'(mreq_valid), 64'd1);
    check_vec("st_mreq_addr", 64'(mreq_addr), 64'h0);
    redirect(32'h40);
    check_vec("st_mreq_valid2", 64'(mreq_valid), 64'd1);
    check_vec("st_mreq_addr2", 64'(mreq_addr), 64'h40);
    mreq_ready = 1'b1;
    ticks(10);
    check_vec("st_req0", 64'(req_log[0]), 64'h40);
    check_vec("st_pop0_addr", 64'(pop_addr[0]), 64'h40);
    check_vec("st_pop0_id", pop_id[0], 64'd0);
    check_vec("st_pop0_inst", 64'(pop_inst[0]), 64'hC0DE_0040);

    // reset mid-WAIT, then a stray response while IDLE
    do_reset();
    mem_lat = 3;
    ticks(6);
    run_until_req("mr_wait_req", 2);
    rst_n = 1'b0;
    #1;
    check_vec("mr_async_valid", 64'(iresp_valid), 64'd0);
    check_vec("mr_async_addr", 64'(mreq_addr), 64'h0);
    pend = 1'b0; mem_lat = 1;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
    mresp_valid = 1'b1; mresp_data = 32'hDEAD_BEEF;
    tick();
    ticks(10);
    check_vec("mr_req0", 64'(req_log[0]), 64'h0);
    check_vec("mr_pop0_addr", 64'(pop_addr[0]), 64'h0);
    check_vec("mr_pop0_id", pop_id[0], 64'd0);
    check_vec("mr_pop0_inst", 64'(pop_inst[0]), 64'hC0DE_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
